// File: rtl/cbx_param_cfg_if.sv
// Configuration-chain bus for the connection block: serial load, commit
// request and the status flags that come back from the block.
interface cbx_param_cfg_if;
  logic config_enable;
  logic ccff_head;
  logic cfg_commit;
  logic ccff_tail;
  logic cfg_valid;
  logic cfg_err;

  modport master (
    output config_enable,
    output ccff_head,
    output cfg_commit,
    input  ccff_tail,
    input  cfg_valid,
    input  cfg_err
  );

  modport slave (
    input  config_enable,
    input  ccff_head,
    input  cfg_commit,
    output ccff_tail,
    output cfg_valid,
    output cfg_err
  );
endinterface

// File: rtl/cbx_param_cfg.sv
// Horizontal connection block with a double-buffered configuration chain.
// Bits are shifted into a shadow register and only copied to the active
// selection on a legal commit, so the ipin muxes never see a partial load.
module cbx_param_cfg #(
  parameter int CHAN_W   = 12,
  parameter int NUM_IPIN = 10,
  parameter int MUX_SIZE = 8
) (
  input  logic                prog_clk,
  input  logic                pReset,
  cbx_param_cfg_if.slave      cfg,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out
);

  localparam int SEL_W = $clog2(MUX_SIZE);
  localparam int TOTAL = NUM_IPIN * SEL_W;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PAIRS = MUX_SIZE / 2;

  logic [TOTAL-1:0] shadow;
  logic [TOTAL-1:0] active;
  logic [CNT_W-1:0] shift_cnt;
  logic             cfg_valid_q;
  logic             cfg_err_q;
  logic             load_full;
  logic             commit_ok;

  logic [NUM_IPIN-1:0][MUX_SIZE-1:0] mux_in;
  logic [NUM_IPIN-1:0][SEL_W-1:0]    sel;

  // A commit is only honoured when the shadow holds a complete, stable load.
  assign load_full = (shift_cnt == CNT_W'(TOTAL));
  assign commit_ok = cfg.cfg_commit && !cfg.config_enable && load_full;

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;

  assign cfg.ccff_tail = shadow[TOTAL-1];
  assign cfg.cfg_valid = cfg_valid_q;
  assign cfg.cfg_err   = cfg_err_q;

  // Shadow chain shifts whenever enabled; the count saturates so extra bits
  // simply stream through to the next block while the load stays complete.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shadow    <= '0;
      shift_cnt <= '0;
    end else if (cfg.config_enable) begin
      shadow <= {shadow[TOTAL-2:0], cfg.ccff_head};
      if (!load_full) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end else if (commit_ok) begin
      shift_cnt <= '0;
    end
  end

  // Active selection only changes on a legal commit, keeping the fabric quiet during reload.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      active      <= '0;
      cfg_valid_q <= 1'b0;
    end else if (commit_ok) begin
      active      <= shadow;
      cfg_valid_q <= 1'b1;
    end
  end

  // Any rejected commit request latches the error flag until the next reset.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      cfg_err_q <= 1'b0;
    end else if (cfg.cfg_commit && !commit_ok) begin
      cfg_err_q <= 1'b1;
    end
  end

  // Each mux sees one left/right track pair per even/odd input, spread evenly
  // across the channel and rotated by the mux index.
  for (genvar j = 0; j < NUM_IPIN; j++) begin : g_ipin
    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
      localparam int TRACK = ((p * CHAN_W) / PAIRS + j) % CHAN_W;
      assign mux_in[j][2*p]   = chanx_left_in[TRACK];
      assign mux_in[j][2*p+1] = chanx_right_in[TRACK];
    end

    assign sel[j] = active[j*SEL_W +: SEL_W];

    if (MUX_SIZE == (1 << SEL_W)) begin : g_full
      assign ipin_out[j] = cfg_valid_q ? mux_in[j][sel[j]] : 1'b0;
    end else begin : g_partial
      assign ipin_out[j] = (cfg_valid_q && (int'(sel[j]) < MUX_SIZE))
                           ? mux_in[j][sel[j]] : 1'b0;
    end
  end

endmodule
